// File: rtl/regfile_writeback.sv
// Register-file writer: merges single-cycle ALU results with buffered load results
// into one registered write per cycle, and keeps a pending-write scoreboard for decode.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_issue_valid,
    input  logic [4:0]      i_issue_rd,
    output logic            o_issue_ready,
    input  logic [4:0]      i_rs1_address,
    input  logic [4:0]      i_rs2_address,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_value,
    input  logic            i_mem_valid,
    output logic            o_mem_ready,
    input  logic [4:0]      i_mem_rd,
    input  logic [XLEN-1:0] i_mem_value,
    output logic [4:0]      o_wb_rd_address,
    output logic [XLEN-1:0] o_wb_rd_value
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [4:0]       r_fifo_rd  [DEPTH];
    logic [XLEN-1:0]  r_fifo_val [DEPTH];
    logic [31:0]      r_pending;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_alu_wr;
    logic             w_issue_fire;
    logic [31:0]      w_pending_nxt;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

    assign o_mem_ready  = !w_full;
    assign w_push       = i_mem_valid && !w_full && (i_mem_rd != 5'd0);
    assign w_alu_wr     = i_alu_valid && (i_alu_rd != 5'd0);
    assign w_pop        = !w_alu_wr && !w_empty;

    assign o_issue_ready = !((i_issue_rd != 5'd0) && r_pending[i_issue_rd]);
    assign w_issue_fire  = i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0);

    assign o_rs1_busy = (i_rs1_address != 5'd0) && r_pending[i_rs1_address];
    assign o_rs2_busy = (i_rs2_address != 5'd0) && r_pending[i_rs2_address];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[w_wr_idx]  <= i_mem_rd;
            r_fifo_val[w_wr_idx] <= i_mem_value;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_rd_address <= 5'd0;
            o_wb_rd_value   <= '0;
        end else if (w_alu_wr) begin
            o_wb_rd_address <= i_alu_rd;
            o_wb_rd_value   <= i_alu_value;
        end else if (w_pop) begin
            o_wb_rd_address <= r_fifo_rd[w_rd_idx];
            o_wb_rd_value   <= r_fifo_val[w_rd_idx];
        end else begin
            o_wb_rd_address <= 5'd0;
        end
    end

    // Clear on commit first so a same-edge re-issue of that register stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (o_wb_rd_address != 5'd0) begin
            w_pending_nxt[o_wb_rd_address] = 1'b0;
        end
        if (w_issue_fire) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random traffic,
// all compared against a queue/array reference model of the writeback rules.
module tb_regfile_writeback;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      rs1_address;
    logic [4:0]      rs2_address;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_value;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_value;
    logic [4:0]      wb_rd_address;
    logic [XLEN-1:0] wb_rd_value;

    int checks = 0;
    int errors = 0;

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_issue_valid  (issue_valid),
        .i_issue_rd     (issue_rd),
        .o_issue_ready  (issue_ready),
        .i_rs1_address  (rs1_address),
        .i_rs2_address  (rs2_address),
        .o_rs1_busy     (rs1_busy),
        .o_rs2_busy     (rs2_busy),
        .i_alu_valid    (alu_valid),
        .i_alu_rd       (alu_rd),
        .i_alu_value    (alu_value),
        .i_mem_valid    (mem_valid),
        .o_mem_ready    (mem_ready),
        .i_mem_rd       (mem_rd),
        .i_mem_value    (mem_value),
        .o_wb_rd_address(wb_rd_address),
        .o_wb_rd_value  (wb_rd_value)
    );

    always #5 clk = ~clk;

    // Reference model: queue of buffered loads, per-register pending flags, wb regs.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
    } ent_t;

    ent_t            m_q[$];
    bit              m_pend[32];
    logic [4:0]      m_wb_addr;
    logic [XLEN-1:0] m_wb_val;
    int              m_pushes;

    function automatic bit mdl_mem_ready();
        return m_q.size() < DEPTH;
    endfunction

    function automatic bit mdl_issue_ready(logic [4:0] rd);
        return !(rd != 0 && m_pend[rd]);
    endfunction

    function automatic bit mdl_busy(logic [4:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    task automatic mdl_reset();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wb_addr = '0;
        m_wb_val  = '0;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; rs1_address = 0; rs2_address = 0;
        alu_valid = 0; alu_rd = 0; alu_value = 0;
        mem_valid = 0; mem_rd = 0; mem_value = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic tick();
        bit              s_rst, s_fire, s_acc, s_alu;
        logic [4:0]      s_ir60, s_alurd, s_memrd;
        logic [XLEN-1:0] s_aluv, s_memv;
        ent_t            e;
        s_rst   = !rst_n;
        s_fire  = issue_valid && issue_rd != 0 && mdl_issue_ready(issue_rd);
        s_ir60  = issue_rd;
        s_alu   = alu_valid && alu_rd != 0;
        s_alurd = alu_rd;  s_aluv = alu_value;
        s_acc   = mem_valid && mdl_mem_ready();
        s_memrd = mem_rd;  s_memv = mem_value;
        @(posedge clk);
        if (!s_rst) begin
            if (m_wb_addr != 0) m_pend[m_wb_addr] = 1'b0;
            if (s_fire) m_pend[s_ir60] = 1'b1;
            if (s_alu) begin
                m_wb_addr = s_alurd; m_wb_val = s_aluv;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_wb_addr = e.rd; m_wb_val = e.val;
            end else begin
                m_wb_addr = '0;
            end
            if (s_acc && s_memrd != 0) begin
                m_q.push_back('{rd: s_memrd, val: s_memv});
                m_pushes++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        issue_rd = 5;
        rs1_address = 5;
        mdl_reset();
        #3;
        checks++; if (wb_rd_address !== 5'd0) begin errors++; $display("FAIL reset_wb_addr: got %0d expected 0", wb_rd_address); end
        checks++; if (wb_rd_value !== '0) begin errors++; $display("FAIL reset_wb_value: got %0h expected 0", wb_rd_value); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %0b expected 1", mem_ready); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0b expected 1", issue_ready); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy: got %0b expected 0", rs1_busy); end
        tick(); tick();
        rst_n = 1;
        issue_rd = 0; rs1_address = 0;
        tick();
    endtask

    task automatic test_alu_latency();
        alu_valid = 1; alu_rd = 5; alu_value = 32'h1234;
        tick();
        idle_inputs();
        checks++; if (wb_rd_address !== 5'd5) begin errors++; $display("FAIL alu_wb_addr: got %0d expected 5", wb_rd_address); end
        checks++; if (wb_rd_value !== 32'h1234) begin errors++; $display("FAIL alu_wb_value: got %0h expected 1234", wb_rd_value); end
        tick();
        checks++; if (wb_rd_address !== 5'd0) begin errors++; $display("FAIL alu_wb_idle: got %0d expected 0", wb_rd_address); end
        checks++; if (wb_rd_value !== 32'h1234) begin errors++; $display("FAIL alu_wb_hold: got %0h expected 1234", wb_rd_value); end
        alu_valid = 1; alu_rd = 0; alu_value = 32'hDEAD;
        tick();
        idle_inputs();
        checks++; if (wb_rd_address !== 5'd0) begin errors++; $display("FAIL alu_x0_dropped: got %0d expected 0", wb_rd_address); end
    endtask

    task automatic test_mem_scoreboard();
        issue_valid = 1; issue_rd = 7; rs1_address = 7;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_issue_ready: got %0b expected 1", issue_ready); end
        tick();
        issue_valid = 0; issue_rd = 0;
        #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_after_issue: got %0b expected 1", rs1_busy); end
        tick(); tick();
        mem_valid = 1; mem_rd = 7; mem_value = 32'hCAFE;
        tick();
        mem_valid = 0; mem_rd = 0; mem_value = 0;
        #1;
        checks++; if (wb_rd_address !== 5'd0) begin errors++; $display("FAIL sb_load_in_fifo: got %0d expected 0", wb_rd_address); end
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_in_fifo: got %0b expected 1", rs1_busy); end
        tick();
        checks++; if (wb_rd_address !== 5'd7) begin errors++; $display("FAIL sb_load_wb_addr: got %0d expected 7", wb_rd_address); end
        checks++; if (wb_rd_value !== 32'hCAFE) begin errors++; $display("FAIL sb_load_wb_value: got %0h expected cafe", wb_rd_value); end
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_during_wb: got %0b expected 1", rs1_busy); end
        tick();
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_cleared: got %0b expected 0", rs1_busy); end
        rs1_address = 0;
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_rd = 9;
        tick();
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_second_issue: got %0b expected 0", issue_ready); end
        tick();
        issue_rd = 0; rs1_address = 0; rs2_address = 9;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_x0_ready: got %0b expected 1", issue_ready); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL waw_x0_busy: got %0b expected 0", rs1_busy); end
        checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL waw_rs2_busy: got %0b expected 1", rs2_busy); end
        tick();
        issue_rd = 9; alu_valid = 1; alu_rd = 9; alu_value = 32'h99;
        tick();
        alu_valid = 0; alu_rd = 0;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_ready_before_commit: got %0b expected 0", issue_ready); end
        tick();
        issue_valid = 0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_ready_after_commit: got %0b expected 1", issue_ready); end
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_priority();
        int k = 0;
        int exp_next = 10;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(20 + i); alu_value = $urandom;
            mem_valid = (k < 5); mem_rd = 5'(10 + k); mem_value = $urandom;
            #1;
            if (i == 4) begin
                checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL prio_full_after_4: got %0b expected 0", mem_ready); end
            end
            if (mdl_mem_ready() && mem_valid) k++;
            tick();
            checks++; if (wb_rd_address !== 5'(20 + i)) begin errors++; $display("FAIL prio_alu_wins: got %0d expected %0d", wb_rd_address, 20 + i); end
        end
        alu_valid = 0; alu_rd = 0;
        for (int i = 0; i < 9; i++) begin
            mem_valid = (k < 5); mem_rd = 5'(10 + k); mem_value = $urandom;
            #1;
            if (mdl_mem_ready() && mem_valid) k++;
            tick();
            if (wb_rd_address != 0) begin
                checks++; if (wb_rd_address !== 5'(exp_next)) begin errors++; $display("FAIL prio_drain_order: got %0d expected %0d", wb_rd_address, exp_next); end
                checks++; if (wb_rd_value !== m_wb_val) begin errors++; $display("FAIL prio_drain_value: got %0h expected %0h", wb_rd_value, m_wb_val); end
                exp_next++;
            end
        end
        checks++; if (exp_next !== 15) begin errors++; $display("FAIL prio_drain_count: got %0d expected 15", exp_next); end
        idle_inputs();
    endtask

    task automatic test_full_refill();
        int pushes0, commits, next_rd;
        for (int i = 0; i < 3; i++) tick();
        pushes0 = m_pushes;
        commits = 0;
        next_rd = 1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'd30; alu_value = $urandom;
            mem_valid = 1; mem_rd = 5'(next_rd); mem_value = $urandom;
            next_rd++;
            tick();
        end
        alu_valid = 0; alu_rd = 0;
        for (int i = 0; i < 12; i++) begin
            mem_valid = 1; mem_rd = 5'(next_rd); mem_value = $urandom;
            #1;
            checks++; if (mem_ready !== mdl_mem_ready()) begin errors++; $display("FAIL refill_mem_ready: got %0b expected %0b", mem_ready, mdl_mem_ready()); end
            if (i == 0) begin
                checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL refill_full_first: got %0b expected 0", mem_ready); end
            end
            if (mdl_mem_ready()) next_rd++;
            tick();
            checks++; if (wb_rd_address !== m_wb_addr || wb_rd_value !== m_wb_val) begin errors++; $display("FAIL refill_wb: got %0d/%0h expected %0d/%0h", wb_rd_address, wb_rd_value, m_wb_addr, m_wb_val); end
            if (wb_rd_address != 0) commits++;
        end
        mem_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wb_rd_address != 0) commits++;
        end
        checks++; if (commits !== m_pushes - pushes0) begin errors++; $display("FAIL refill_no_loss: got %0d commits expected %0d", commits, m_pushes - pushes0); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_rd = 3;
        alu_valid = 1; alu_rd = 31; alu_value = 32'h5;
        mem_valid = 1; mem_rd = 12; mem_value = 32'hAA;
        tick();
        issue_rd = 4; mem_rd = 13;
        tick();
        issue_valid = 0; mem_rd = 14;
        tick();
        idle_inputs();
        rs1_address = 3; rs2_address = 4;
        #2;
        rst_n = 0;
        mdl_reset();
        #1;
        checks++; if (wb_rd_address !== 5'd0) begin errors++; $display("FAIL midrst_wb_addr: got %0d expected 0", wb_rd_address); end
        checks++; if (wb_rd_value !== '0) begin errors++; $display("FAIL midrst_wb_value: got %0h expected 0", wb_rd_value); end
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b%0b expected 00", rs1_busy, rs2_busy); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL midrst_mem_ready: got %0b expected 1", mem_ready); end
        #2;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (wb_rd_address !== 5'd0) begin errors++; $display("FAIL midrst_no_write: got %0d expected 0", wb_rd_address); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_address = 5'($urandom_range(0, 7));
            rs2_address = 5'($urandom_range(0, 7));
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_value   = $urandom;
            mem_valid   = ($urandom_range(0, 1) == 0);
            mem_rd      = 5'($urandom_range(0, 7));
            mem_value   = $urandom;
            #1;
            checks++; if (issue_ready !== mdl_issue_ready(issue_rd)) begin errors++; $display("FAIL rnd_issue_ready: got %0b expected %0b", issue_ready, mdl_issue_ready(issue_rd)); end
            checks++; if (rs1_busy !== mdl_busy(rs1_address) || rs2_busy !== mdl_busy(rs2_address)) begin errors++; $display("FAIL rnd_busy: got %0b%0b expected %0b%0b", rs1_busy, rs2_busy, mdl_busy(rs1_address), mdl_busy(rs2_address)); end
            checks++; if (mem_ready !== mdl_mem_ready()) begin errors++; $display("FAIL rnd_mem_ready: got %0b expected %0b", mem_ready, mdl_mem_ready()); end
            tick();
            checks++; if (wb_rd_address !== m_wb_addr) begin errors++; $display("FAIL rnd_wb_addr: got %0d expected %0d", wb_rd_address, m_wb_addr); end
            checks++; if (wb_rd_value !== m_wb_val) begin errors++; $display("FAIL rnd_wb_value: got %0h expected %0h", wb_rd_value, m_wb_val); end
        end
        idle_inputs();
    endtask

    initial begin
        m_pushes = 0;
        test_reset();
        test_alu_latency();
        test_mem_scoreboard();
        test_waw();
        test_alu_priority();
        test_full_refill();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
